imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Round-robin arbiter that shares one instruction-memory read port between NUM_REQ fetch units, one per core, in the multicore build. It sits between the fetch units' memory-request side and the instruction cache or memory. It tracks outstanding reads in an in-order tag FIFO so that each returned word is steered back to the fetch unit that issued it. Adds zero cycles of latency on the issue path and zero cycles on the return path.

## Interface
- NUM_REQ, 2, number of requesters (fetch units); must be ≥ 2.
- DATA_WIDTH, 32, instruction word width.
- ADDRESS_BITS, 20, byte address width.
- MAX_OUTSTANDING, 2, depth of the tag FIFO; must be a power of two.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_read  in  NUM_REQ  per-requester read request.
- req_address  in  NUM_REQ*ADDRESS_BITS  packed addresses; requester i occupies bits [i*ADDRESS_BITS +: ADDRESS_BITS].
- req_ready  out  NUM_REQ  request i accepted this cycle.
- resp_valid  out  NUM_REQ  returned word belongs to requester i.
- resp_data  out  DATA_WIDTH  returned word, shared by all requesters.
- resp_address  out  ADDRESS_BITS  address of the returned word.
- mem_read  out  1  read issued to memory.
- mem_address  out  ADDRESS_BITS  issued address.
- mem_ready  in  1  memory accepts a read this cycle.
- mem_valid  in  1  memory returns a word; returns are in issue order.
- mem_data  in  DATA_WIDTH  returned word.
- mem_address_in  in  ADDRESS_BITS  address of the returned word.
- report  in  1  prints a summary when the perf feature is compiled in.
- error  out  1  sticky: set when mem_valid arrives with the tag FIFO empty.

## Operation
- Round-robin pointer rr_ptr is a $clog2(NUM_REQ)-bit register.
- Winner: the first i with req_read[i] set, scanning from rr_ptr upward and wrapping modulo NUM_REQ. Selection is combinational.
- mem_read = any req_read && !fifo_full. mem_address = the winner's address.
- Issue: mem_read && mem_ready. On issue:
  - req_ready[winner] = 1; all other req_ready bits stay 0.
  - The winner ID is pushed into the tag FIFO.
  - rr_ptr ← (winner + 1) mod NUM_REQ.
- Without an issue, rr_ptr holds.
- Return: on mem_valid with the FIFO non-empty:
  - resp_valid[head] = 1.
  - resp_data = mem_data and resp_address = mem_address_in.
  - The FIFO pops.
- Same-cycle issue and return are allowed, and the FIFO count is unchanged. When the FIFO is full, a same-cycle pop does NOT enable a push: full is evaluated before the pop.
- mem_valid with the FIFO empty: all resp_valid = 0, error ← 1, and error holds until reset.
- Reset values:
  - rr_ptr = 0, FIFO empty, error = 0.
  - req_ready, resp_valid and mem_read all 0.
  - Perf counters 0.
- Reset mid-flight: outstanding tags are discarded. Any mem_valid after reset with the FIFO empty sets error. The memory is reset by the same reset, so this does not occur in the system.

## Timing
- Issue is combinational in the same cycle: request → mem_read → req_ready. No registered stage.
- Return is combinational: mem_valid → resp_valid. Zero added latency.
- The requester must hold req_read and req_address stable until req_ready is seen.
- FIFO pointers and count update on the rising edge of clk. Count width is $clog2(MAX_OUTSTANDING)+1.
- Fairness: with all NUM_REQ requesters asserting continuously and mem_ready = 1, each requester is granted exactly once in every NUM_REQ consecutive issues.

## Configuration
- IMEM_ARB_PERF_EN defined:
  - Per-requester 32-bit grant counters and 32-bit wait counters. A wait cycle is a cycle with req_read = 1 and req_ready = 0.
  - One 32-bit fifo_full cycle counter.
  - All counters wrap at 2^32.
  - While report = 1, $display prints every counter each cycle.
- IMEM_ARB_PERF_EN undefined: no counters, report is ignored, and logic is otherwise identical.

## Structure
- Package imem_arb_pkg holds:
  - The default parameter constants.
  - The requester-ID width function, $clog2(NUM_REQ).
- Sub-module imem_arb_tag_fifo: synchronous FIFO of requester IDs.
  - Ports: push, pop, din, dout, full, empty.
  - Head is visible combinationally.
- The round-robin scan and the response steering live in the top module.

## Test plan
- After reset, req_read = 2'b11 with mem_ready = 1 every cycle, and the memory returning each read one cycle after issue (mem_valid high on every subsequent cycle) → grants alternate 0,1,0,1. req_ready is never 2'b11. Each resp_valid matches its issuer.
- Requester 0 alone at address 0x10, mem_ready = 0 for 3 cycles, then 1 → req_ready[0] rises in cycle 4 only. mem_address = 0x10 throughout.
- MAX_OUTSTANDING = 2, two issues, mem_valid held low → mem_read = 0 on the third request. A return in cycle N frees the slot and the issue occurs in cycle N+1.
- Issue from requester 1 in the same cycle as requester 0's return → resp_valid = 2'b01 in that cycle, the FIFO count stays at 1, and the next return goes to requester 1.
- mem_valid pulsed with the FIFO empty → error = 1 and resp_valid = 0. error remains 1 until reset is asserted for one cycle, then reads 0.
- IMEM_ARB_PERF_EN defined, 10 cycles of contention between both requesters → grant counters read 5 and 5, and each wait counter is 5.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared constants and helpers for the instruction-memory arbiter.
package imem_arb_pkg;

    localparam int DEF_NUM_REQ         = 2;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_ADDRESS_BITS    = 20;
    localparam int DEF_MAX_OUTSTANDING = 2;
    localparam int PERF_CNT_WIDTH      = 32;

    // Width of a requester ID; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imem_arb_tag_fifo.sv
// In-order FIFO of requester IDs for reads still in flight at the memory.
// The head entry is visible combinationally so a return can be steered in
// the same cycle it arrives. Pushes while full and pops while empty are
// dropped; full is evaluated on the pre-pop state.
module imem_arb_tag_fifo
    import imem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_OUTSTANDING,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port between
// NUM_REQ fetch units. Issue and return paths are purely combinational;
// an in-order tag FIFO remembers which fetch unit owns each in-flight read.
// Optional feature macro: IMEM_ARB_PERF_EN adds grant/wait/full counters
// and a per-cycle $display dump while report is high.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDRESS_BITS    = DEF_ADDRESS_BITS,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_read,
    input  logic [NUM_REQ*ADDRESS_BITS-1:0] req_address,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_data,
    output logic [ADDRESS_BITS-1:0]         resp_address,
    output logic                            mem_read,
    output logic [ADDRESS_BITS-1:0]         mem_address,
    input  logic                            mem_ready,
    input  logic                            mem_valid,
    input  logic [DATA_WIDTH-1:0]           mem_data,
    input  logic [ADDRESS_BITS-1:0]         mem_address_in,
    input  logic                            report,
    output logic                            error
);

    localparam int IDW = id_width(NUM_REQ);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] scan_idx;
    logic [IDW:0]   scan_sum;
    logic           any_req;
    logic           issue;
    logic           ret;
    logic           fifo_full;
    logic           fifo_empty;
    logic [IDW-1:0] fifo_head;

    // Round-robin scan: first requester at or after rr_ptr, wrapping.
    always_comb begin
        winner   = '0;
        scan_sum = '0;
        scan_idx = '0;
        any_req  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!any_req && req_read[scan_idx]) begin
                winner  = scan_idx;
                any_req = 1'b1;
            end
        end
    end

    // Reset masks the combinational handshakes so the port looks idle
    // while the tag FIFO is being cleared.
    assign mem_read    = any_req && !fifo_full && !reset;
    assign mem_address = req_address[winner*ADDRESS_BITS +: ADDRESS_BITS];
    assign issue       = mem_read && mem_ready;
    assign req_ready   = issue ? (NUM_REQ'(1) << winner) : '0;

    assign ret          = mem_valid && !fifo_empty && !reset;
    assign resp_valid   = ret ? (NUM_REQ'(1) << fifo_head) : '0;
    assign resp_data    = mem_data;
    assign resp_address = mem_address_in;

    imem_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (issue),
        .pop   (ret),
        .din   (winner),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
        end
    end

    // Sticky flag for a return with nothing outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            error <= 1'b0;
        end else if (mem_valid && fifo_empty) begin
            error <= 1'b1;
        end
    end

`ifdef IMEM_ARB_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] grant_cnt [NUM_REQ];
    logic [PERF_CNT_WIDTH-1:0] wait_cnt  [NUM_REQ];
    logic [PERF_CNT_WIDTH-1:0] full_cnt;

    // Per-requester grant/wait counters and fifo-full cycle counter; all wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
                wait_cnt[i]  <= '0;
            end
            full_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    grant_cnt[i] <= grant_cnt[i] + 1'b1;
                end
                if (req_read[i] && !req_ready[i]) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
            if (fifo_full) begin
                full_cnt <= full_cnt + 1'b1;
            end
        end
    end

    // Simulation-visible dump of every counter while report is held.
    always_ff @(posedge clk) begin
        if (report) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                $display("imem_arbiter perf: req %0d grants %0d waits %0d",
                         i, grant_cnt[i], wait_cnt[i]);
            end
            $display("imem_arbiter perf: fifo_full cycles %0d", full_cnt);
        end
    end
`else
    logic unused_report;
    assign unused_report = report;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with hand-computed expectations.
module tb_imem_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 20;
    localparam int MO = 2;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_read;
    logic [NR*AW-1:0] req_address;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    resp_valid;
    logic [DW-1:0]    resp_data;
    logic [AW-1:0]    resp_address;
    logic             mem_read;
    logic [AW-1:0]    mem_address;
    logic             mem_ready;
    logic             mem_valid;
    logic [DW-1:0]    mem_data;
    logic [AW-1:0]    mem_address_in;
    logic             report;
    logic             error;

    int n_tests;
    int n_fail;

    imem_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_address(req_address), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_address(resp_address),
        .mem_read(mem_read), .mem_address(mem_address), .mem_ready(mem_ready),
        .mem_valid(mem_valid), .mem_data(mem_data), .mem_address_in(mem_address_in),
        .report(report), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, settle, then return for checks.
    task automatic cyc(input logic [1:0] rd, input logic mr, input logic mv, input logic [31:0] md);
        @(negedge clk);
        req_read       = rd;
        mem_ready      = mr;
        mem_valid      = mv;
        mem_data       = md;
        mem_address_in = md[19:0];
        #1;
    endtask

    logic [1:0] t1_rdy [4];
    logic [1:0] t1_rv  [4];
    logic [1:0] t3_rdy [5];
    logic [1:0] t3_rv  [5];
    logic       t3_mr  [5];
    logic       t3_mv  [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        req_read = '0;
        req_address = {20'h00200, 20'h00100};
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_data = '0;
        mem_address_in = '0;
        report = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_error", error, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_read", mem_read, 0);

        // Both requesters, one-cycle memory returns: grants alternate.
        t1_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
        t1_rv  = '{2'b00, 2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 1'b1, (i > 0), 32'hA000_0000 + i);
            check($sformatf("alt_rdy%0d", i), req_ready, t1_rdy[i]);
            check($sformatf("alt_rv%0d", i), resp_valid, t1_rv[i]);
        end
        check("alt_rdata", resp_data, 32'hA000_0003);
        cyc(2'b00, 1'b1, 1'b1, 32'hA000_0004);
        check("alt_drain_rv", resp_valid, 2'b10);
        check("alt_drain_mr", mem_read, 0);

        // Requester 0 alone, memory stalls three cycles.
        req_address[19:0] = 20'h00010;
        for (int i = 0; i < 3; i++) begin
            cyc(2'b01, 1'b0, 1'b0, 32'h0);
            check($sformatf("stall_rdy%0d", i), req_ready, 2'b00);
            check($sformatf("stall_mr%0d", i), mem_read, 1);
            check($sformatf("stall_addr%0d", i), mem_address, 20'h00010);
        end
        cyc(2'b01, 1'b1, 1'b0, 32'h0);
        check("stall_rdy3", req_ready, 2'b01);
        check("stall_addr3", mem_address, 20'h00010);
        cyc(2'b00, 1'b1, 1'b1, 32'h1234_5678);
        check("stall_ret_rv", resp_valid, 2'b01);
        check("stall_ret_addr", resp_address, 20'h45678);
        check("stall_ret_data", resp_data, 32'h1234_5678);

        // FIFO full: third request blocked; a return frees the slot next cycle.
        t3_mv  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t3_rdy = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
        t3_mr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        t3_rv  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
        for (int i = 0; i < 5; i++) begin
            cyc(2'b11, 1'b1, t3_mv[i], 32'hB000_0000 + i);
            check($sformatf("full_rdy%0d", i), req_ready, t3_rdy[i]);
            check($sformatf("full_mr%0d", i), mem_read, t3_mr[i]);
            check($sformatf("full_rv%0d", i), resp_valid, t3_rv[i]);
        end
        cyc(2'b00, 1'b1, 1'b1, 32'h0);
        check("full_drain_rv0", resp_valid, 2'b01);
        cyc(2'b00, 1'b1, 1'b1, 32'h0);
        check("full_drain_rv1", resp_valid, 2'b10);

        // Same-cycle issue (req 1) and return (req 0).
        cyc(2'b01, 1'b1, 1'b0, 32'h0);
        check("same_rdy0", req_ready, 2'b01);
        cyc(2'b10, 1'b1, 1'b1, 32'h0);
        check("same_rdy1", req_ready, 2'b10);
        check("same_rv1", resp_valid, 2'b01);
        cyc(2'b00, 1'b1, 1'b1, 32'h0);
        check("same_rv2", resp_valid, 2'b10);

        // Return with nothing outstanding: sticky error.
        cyc(2'b00, 1'b1, 1'b0, 32'h0);
        check("err_before", error, 0);
        cyc(2'b00, 1'b1, 1'b1, 32'h0);
        check("err_rv", resp_valid, 2'b00);
        cyc(2'b00, 1'b1, 1'b0, 32'h0);
        check("err_set", error, 1);
        cyc(2'b00, 1'b1, 1'b0, 32'h0);
        check("err_hold", error, 1);
        @(negedge clk);
        reset = 1'b1;
        req_read = 2'b11;
        #1;
        check("rst_mid_mr", mem_read, 0);
        check("rst_mid_rdy", req_ready, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        req_read = 2'b00;
        #1;
        check("err_cleared", error, 0);

        // Ten cycles of contention from reset: rr_ptr starts at 0.
        for (int i = 0; i < 10; i++) begin
            cyc(2'b11, 1'b1, (i > 0), 32'hC000_0000 + i);
            check($sformatf("cont_rdy%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        cyc(2'b00, 1'b1, 1'b1, 32'h0);
        check("cont_drain_rv", resp_valid, 2'b10);
`ifdef IMEM_ARB_PERF_EN
        check("perf_grant0", dut.grant_cnt[0], 5);
        check("perf_grant1", dut.grant_cnt[1], 5);
        check("perf_wait0", dut.wait_cnt[0], 5);
        check("perf_wait1", dut.wait_cnt[1], 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
